si_inst_injector: RTL and testbench
===================================

Name: si_inst_injector

Overview:
Instruction-feed sequencer for single-instruction (SI) formal checking of the ridecore pipeline. It sits directly upstream of the fetch stage and the instruction-legality decode. It presents NOPs during warm-up, then injects one held symbolic instruction. It then drains with NOPs until the instruction retires and raises a one-cycle check window for the SI property checker.

Parameters:
WARMUP_CYCLES, 4, NOP cycles before injection; legal range 1..255.
DRAIN_MAX, 32, maximum drain cycles to wait for retirement before timeout; legal range 1..255.
NOP_INST, 32'h0000007F, stall encoding (opcode 7'b1111111) driven whenever no instruction is offered.

Ports:
clk  in  1  clock
reset_x  in  1  asynchronous active-low reset
start  in  1  begin a sequence; sampled only in IDLE
sym_inst  in  32  unconstrained solver-driven instruction word
fetch_stall  in  1  fetch cannot accept this cycle
retire_cnt  in  2  instructions committed this cycle (0..2)
inst_out  out  32  instruction word to fetch/decode
inst_valid  out  1  inst_out is a real instruction
held_inst  out  32  latched instruction under test, for the checker
busy  out  1  state is WARMUP, INJECT or DRAIN
check_en  out  1  one-cycle check window
done  out  1  sequence finished (sticky)
timeout  out  1  drain expired without retirement (sticky)
spurious_retire  out  1  retirement seen outside DRAIN (sticky)

Behaviour:
- Reset (async, reset_x=0) values:
  - state=IDLE, counter=0, retired=0.
  - inst_out=NOP_INST, held_inst=0.
  - inst_valid=check_en=done=timeout=spurious_retire=busy=0.
  - Reset mid-sequence aborts immediately to these values.
- All outputs are registered except inst_out and inst_valid, which are decoded from state and held_inst.
- IDLE: drive NOP, inst_valid=0. start=1 -> WARMUP, counter<=0.
- WARMUP:
  - Drive NOP, counter increments each cycle.
  - When counter==WARMUP_CYCLES-1: held_inst<=sym_inst, counter<=0, -> INJECT.
- INJECT:
  - inst_out=held_inst, inst_valid=1. held_inst stays stable while stalled.
  - fetch_stall=0: accepted at that edge, -> DRAIN, counter<=0.
  - fetch_stall=1: remain in INJECT, no limit.
- DRAIN:
  - Drive NOP, inst_valid=0.
  - retire_cnt!=0 -> CHECK; retired<=1 (saturates).
  - Else if counter==DRAIN_MAX-1 -> DONE with timeout<=1.
  - Else counter++.
  - Retirement on the final drain cycle takes priority over timeout.
- CHECK: check_en=1 for exactly this cycle, NOP driven, -> DONE.
- DONE: NOP driven, done=1; held_inst, timeout and spurious_retire hold. Only reset leaves DONE; start is ignored.
- spurious_retire<=1 if retire_cnt!=0 in IDLE, WARMUP, INJECT or CHECK. The state flow is unaffected.
- Widths:
  - counter is 8 bits.
  - retire_cnt=3 is treated as non-zero, and spurious_retire is not set for it.
- busy is registered and equals (next state in {WARMUP, INJECT, DRAIN}), so it is aligned with the state register.

Decomposition:
- Shared package si_pkg holds:
  - the state enum (IDLE, WARMUP, INJECT, DRAIN, CHECK, DONE);
  - the NOP opcode constant 7'b1111111 and the default NOP_INST word;
  - the opcode constants for OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI and AUIPC, shared with the legality decode.
- No sub-module. The counter and FSM are a single always block plus output decode.

Test Plan:
- start=1 at cycle 2, WARMUP_CYCLES=4, fetch_stall=0, sym_inst=32'h00208133 (ADD x2,x1,x2), retire_cnt=1 at 3rd DRAIN cycle -> inst_valid=1 for exactly one cycle carrying 32'h00208133; check_en pulses once; done=1; timeout=0.
- Same sequence, but fetch_stall=1 for 3 INJECT cycles and sym_inst toggled to 32'hFFFFFFFF during the stall -> inst_out stays 32'h00208133 for 4 cycles; acceptance on the 4th.
- No retirement, DRAIN_MAX=32 -> timeout=1 and done=1 exactly 32 cycles after entering DRAIN; check_en never asserts.
- retire_cnt=2 on the final drain cycle (counter=31) -> CHECK taken, timeout=0.
- retire_cnt=1 during WARMUP -> spurious_retire=1, sequence otherwise completes normally.
- reset_x=0 asynchronously mid-DRAIN -> all outputs at reset values within the same cycle; start after release restarts the sequence from WARMUP.

Source files
------------

// File: rtl/si_pkg.sv
// Shared definitions for the single-instruction injection harness and the
// instruction-legality decode that sits beside it.
package si_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    INJECT = 3'd2,
    DRAIN  = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5
  } state_e;

  localparam logic [6:0]  NOP_OPCODE       = 7'b1111111;
  localparam logic [31:0] NOP_INST_DEFAULT = {25'd0, NOP_OPCODE};

  // RV32I major opcodes recognised by the legality decode
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

endpackage

// File: rtl/si_inst_injector.sv
// Instruction-feed sequencer: NOP warm-up, one held symbolic instruction,
// NOP drain until retirement, then a single-cycle check window.
module si_inst_injector
  import si_pkg::*;
#(
  parameter int unsigned WARMUP_CYCLES = 4,
  parameter int unsigned DRAIN_MAX     = 32,
  parameter logic [31:0] NOP_INST      = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        start,
  input  logic [31:0] sym_inst,
  input  logic        fetch_stall,
  input  logic [1:0]  retire_cnt,
  output logic [31:0] inst_out,
  output logic        inst_valid,
  output logic [31:0] held_inst,
  output logic        busy,
  output logic        check_en,
  output logic        done,
  output logic        timeout,
  output logic        spurious_retire
);

  localparam logic [7:0] WARM_LAST  = 8'(WARMUP_CYCLES - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

  state_e      state, state_nxt;
  logic [7:0]  counter, counter_nxt;
  logic [31:0] held_nxt;
  logic        retired, retired_nxt;
  logic        timeout_nxt, spurious_nxt;
  logic        retire_any, retire_spur;

  assign retire_any  = (retire_cnt != 2'd0);
  // code 3 is not a legal commit count, so it never flags a spurious retire
  assign retire_spur = (retire_cnt == 2'd1) || (retire_cnt == 2'd2);

  always_comb begin
    state_nxt    = state;
    counter_nxt  = counter;
    held_nxt     = held_inst;
    retired_nxt  = retired;
    timeout_nxt  = timeout;
    spurious_nxt = spurious_retire;
    unique case (state)
      IDLE:
        if (start) begin
          state_nxt   = WARMUP;
          counter_nxt = '0;
        end
      WARMUP:
        if (counter == WARM_LAST) begin
          held_nxt    = sym_inst;
          counter_nxt = '0;
          state_nxt   = INJECT;
        end else begin
          counter_nxt = counter + 8'd1;
        end
      INJECT:
        if (!fetch_stall) begin
          state_nxt   = DRAIN;
          counter_nxt = '0;
        end
      DRAIN:
        // retirement wins over timeout on the last drain cycle
        if (retire_any) begin
          state_nxt   = CHECK;
          retired_nxt = 1'b1;
        end else if (counter == DRAIN_LAST) begin
          state_nxt   = DONE;
          timeout_nxt = 1'b1;
        end else begin
          counter_nxt = counter + 8'd1;
        end
      CHECK:   state_nxt = DONE;
      default: state_nxt = state;
    endcase
    if (retire_spur && (state inside {IDLE, WARMUP, INJECT, CHECK}))
      spurious_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state           <= IDLE;
      counter         <= '0;
      retired         <= 1'b0;
      held_inst       <= '0;
      busy            <= 1'b0;
      check_en        <= 1'b0;
      done            <= 1'b0;
      timeout         <= 1'b0;
      spurious_retire <= 1'b0;
    end else begin
      state           <= state_nxt;
      counter         <= counter_nxt;
      retired         <= retired_nxt;
      held_inst       <= held_nxt;
      busy            <= state_nxt inside {WARMUP, INJECT, DRAIN};
      check_en        <= (state_nxt == CHECK);
      done            <= (state_nxt == DONE);
      timeout         <= timeout_nxt;
      spurious_retire <= spurious_nxt;
    end
  end

  assign inst_valid = (state == INJECT);
  assign inst_out   = inst_valid ? held_inst : NOP_INST;

endmodule

// File: tb/tb_si_inst_injector.sv
// Randomized scoreboard bench: each sequence pushes its expected inject,
// check and done events; a negedge monitor pops them as the DUT shows them.
module tb_si_inst_injector;

  localparam int W  = 4;
  localparam int DM = 32;
  localparam logic [31:0] NOP = 32'h0000007F;

  logic        clk = 1'b0;
  logic        reset_x, start, fetch_stall;
  logic [31:0] sym_inst;
  logic [1:0]  retire_cnt;
  logic [31:0] inst_out, held_inst;
  logic        inst_valid, busy, check_en, done, timeout, spurious_retire;

  si_inst_injector #(.WARMUP_CYCLES(W), .DRAIN_MAX(DM), .NOP_INST(NOP)) dut (
    .clk(clk), .reset_x(reset_x), .start(start), .sym_inst(sym_inst),
    .fetch_stall(fetch_stall), .retire_cnt(retire_cnt), .inst_out(inst_out),
    .inst_valid(inst_valid), .held_inst(held_inst), .busy(busy),
    .check_en(check_en), .done(done), .timeout(timeout),
    .spurious_retire(spurious_retire)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] data; } ev_t;
  typedef struct { int cyc; logic to; logic sp; } done_t;
  ev_t   inj_q[$];
  ev_t   chk_q[$];
  done_t done_q[$];
  int    busy_from = 1, busy_to = 0;
  int    total = 0, bad = 0;
  logic  prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s unexpected event (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    ev_t   ev;
    done_t de;
    chk("busy", 32'(busy), 32'(cyc >= busy_from && cyc <= busy_to));
    if (inst_valid) begin
      if (inj_q.size() == 0) unexpected("inject");
      else begin
        ev = inj_q.pop_front();
        chk("inject_cycle", 32'(cyc), 32'(ev.cyc));
        chk("inject_word", inst_out, ev.data);
      end
    end else chk("nop_word", inst_out, NOP);
    if (check_en) begin
      if (chk_q.size() == 0) unexpected("check_en");
      else begin
        ev = chk_q.pop_front();
        chk("check_cycle", 32'(cyc), 32'(ev.cyc));
      end
    end
    if (done && !prev_done) begin
      if (done_q.size() == 0) unexpected("done");
      else begin
        de = done_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(de.cyc));
        chk("timeout", 32'(timeout), 32'(de.to));
        chk("spurious", 32'(spurious_retire), 32'(de.sp));
      end
    end
    prev_done <= done;
  end

  task automatic chk_reset_vals();
    chk("rst_inst_out", inst_out, NOP);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_held", held_inst, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_check_en", 32'(check_en), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_spurious", 32'(spurious_retire), 0);
  endtask

  task automatic clear_exp();
    inj_q.delete();
    chk_q.delete();
    done_q.delete();
    busy_from = 1;
    busy_to   = 0;
  endtask

  // called #1 after a rising edge
  task automatic do_reset();
    start = 0; fetch_stall = 0; retire_cnt = 0;
    reset_x = 1'b0;
    #1;
    clear_exp();
    chk_reset_vals();
    @(posedge clk); #1;
    reset_x = 1'b1;
  endtask

  // rdrain: drain cycle index carrying retirement (-1 = none);
  // spur_at: warm-up cycle index carrying spur_val (-1 = none);
  // abort_at: drain cycle index at which reset is pulsed (-1 = none)
  task automatic run_seq(input logic [31:0] w, input int stall, input int rdrain,
                         input logic [1:0] rval, input int spur_at,
                         input logic [1:0] spur_val, input int abort_at);
    int k0, inj0, d0, end_e;
    ev_t ev;
    done_t de;
    k0   = cyc + 1;
    inj0 = k0 + W;
    d0   = inj0 + stall + 1;
    for (int i = 0; i <= stall; i++) begin
      ev.cyc = inj0 + i; ev.data = w; inj_q.push_back(ev);
    end
    de.sp = (spur_at >= 0) && (spur_val == 2'd1 || spur_val == 2'd2);
    if (rdrain >= 0) begin
      ev.cyc = d0 + rdrain + 1; ev.data = '0; chk_q.push_back(ev);
      de.cyc = d0 + rdrain + 2; de.to = 1'b0; busy_to = d0 + rdrain;
    end else begin
      de.cyc = d0 + DM; de.to = 1'b1; busy_to = d0 + DM - 1;
    end
    done_q.push_back(de);
    busy_from = k0;
    end_e = de.cyc;
    for (int e = k0; e <= end_e; e++) begin
      start       = (e == k0);
      fetch_stall = (e > inj0 && e <= inj0 + stall);
      sym_inst    = (e == inj0) ? w : ((e > inj0) ? 32'hFFFFFFFF : $urandom);
      retire_cnt  = 2'd0;
      if (spur_at >= 0 && e == k0 + 1 + spur_at) retire_cnt = spur_val;
      if (rdrain >= 0 && e == d0 + rdrain + 1) retire_cnt = rval;
      @(posedge clk); #1;
      if (abort_at >= 0 && e == d0 + abort_at) begin
        #2 reset_x = 1'b0;
        #1;
        clear_exp();
        chk_reset_vals();
        start = 0; fetch_stall = 0; retire_cnt = 0;
        @(posedge clk); #1;
        chk("abort_held_idle", 32'(busy), 0);
        reset_x = 1'b1;
        return;
      end
    end
    // DONE must ignore start and late retirements
    start = 1'b1; retire_cnt = 2'd1;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b0; retire_cnt = 2'd0;
    chk("final_done", 32'(done), 1);
    chk("final_timeout", 32'(timeout), 32'(de.to));
    chk("final_spurious", 32'(spurious_retire), 32'(de.sp));
    chk("final_held", held_inst, w);
    chk("final_check_en", 32'(check_en), 0);
    chk("left_inject", 32'(inj_q.size()), 0);
    chk("left_check", 32'(chk_q.size()), 0);
    chk("left_done", 32'(done_q.size()), 0);
  endtask

  initial begin
    reset_x = 1'b0; start = 0; sym_inst = '0; fetch_stall = 0; retire_cnt = 0;
    @(posedge clk); #1;
    chk_reset_vals();
    @(posedge clk); #1;
    reset_x = 1'b1;

    run_seq(32'h00208133, 0,  2, 2'd1, -1, 2'd0, -1);
    do_reset();
    run_seq(32'h00208133, 3,  2, 2'd1, -1, 2'd0, -1);
    do_reset();
    run_seq(32'h00208133, 0, -1, 2'd0, -1, 2'd0, -1);
    do_reset();
    run_seq(32'h00208133, 0, 31, 2'd2, -1, 2'd0, -1);
    do_reset();
    run_seq(32'h00208133, 0,  2, 2'd1,  1, 2'd1, -1);
    do_reset();
    run_seq(32'h00208133, 1, -1, 2'd0, -1, 2'd0,  5);
    run_seq(32'h40110133, 0,  0, 2'd3,  3, 2'd3, -1);

    for (int n = 0; n < 20; n++) begin
      int rd, sp;
      do_reset();
      rd = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, DM - 1));
      sp = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, W - 1));
      run_seq($urandom, int'($urandom_range(0, 5)), rd, 2'($urandom_range(1, 3)),
              sp, 2'($urandom_range(1, 3)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
